// File: rtl/axil_bram_port_arbiter.sv
// rtl/axil_bram_port_arbiter.sv - two-master AXI-Lite round-robin arbiter for one BRAM port
//
// Purpose: serialises AXI-Lite traffic from masters s0 and s1 onto a single
// downstream port (m_axil_*). At most one transaction is outstanding downstream.
// Four request slots (0=S0W 1=S0R 2=S1W 3=S1R) are arbitrated round-robin.
//
// Ports:
//   clka, rstb             clock, synchronous active-high reset
//   s0_axil_*, s1_axil_*   upstream AXI-Lite slave ports (AW, W, B, AR, R)
//   m_axil_*               downstream AXI-Lite master port to the BRAM
//   grant                  slot currently owned (meaningful while busy=1)
//   busy                   1 whenever a transaction is in progress

module axil_bram_port_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
  input  logic [2:0]            s0_axil_awprot,
  input  logic                  s0_axil_awvalid,
  output logic                  s0_axil_awready,
  input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
  input  logic                  s0_axil_wvalid,
  output logic                  s0_axil_wready,
  output logic [1:0]            s0_axil_bresp,
  output logic                  s0_axil_bvalid,
  input  logic                  s0_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
  input  logic [2:0]            s1_axil_awprot,
  input  logic                  s1_axil_awvalid,
  output logic                  s1_axil_awready,
  input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
  input  logic                  s1_axil_wvalid,
  output logic                  s1_axil_wready,
  output logic [1:0]            s1_axil_bresp,
  output logic                  s1_axil_bvalid,
  input  logic                  s1_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,
  output logic [1:0]            grant,
  output logic                  busy
);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RDATA} state_t;

  state_t     state;
  logic [1:0] ptr;
  logic       aw_done, w_done;
  logic [3:0] req;
  logic [1:0] pick;
  logic       sel1;
  logic       in_wr, in_wresp, in_rd, in_rdata;
  logic       sel_awvalid, sel_wvalid, sel_bready, sel_arvalid, sel_rready;
  logic       aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
  logic       aw_hs, w_hs, b_hs, ar_hs, r_hs;

  // Slot index: bit 1 selects the master, bit 0 selects read (1) or write (0).
  assign req = {s1_axil_arvalid, s1_axil_awvalid & s1_axil_wvalid,
                s0_axil_arvalid, s0_axil_awvalid & s0_axil_wvalid};

  // First requesting slot scanning ptr, ptr+1, ... (mod 4).
  always_comb begin
    logic       found;
    logic [1:0] idx;
    pick  = ptr;
    found = 1'b0;
    idx   = ptr;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
  end

  assign sel1     = grant[1];
  assign in_wr    = (state == WR);
  assign in_wresp = (state == WRESP);
  assign in_rd    = (state == RD);
  assign in_rdata = (state == RDATA);
  assign busy     = (state != IDLE);

  assign sel_awvalid = sel1 ? s1_axil_awvalid : s0_axil_awvalid;
  assign sel_wvalid  = sel1 ? s1_axil_wvalid  : s0_axil_wvalid;
  assign sel_bready  = sel1 ? s1_axil_bready  : s0_axil_bready;
  assign sel_arvalid = sel1 ? s1_axil_arvalid : s0_axil_arvalid;
  assign sel_rready  = sel1 ? s1_axil_rready  : s0_axil_rready;

  assign m_axil_awaddr = sel1 ? s1_axil_awaddr : s0_axil_awaddr;
  assign m_axil_awprot = sel1 ? s1_axil_awprot : s0_axil_awprot;
  assign m_axil_wdata  = sel1 ? s1_axil_wdata  : s0_axil_wdata;
  assign m_axil_wstrb  = sel1 ? s1_axil_wstrb  : s0_axil_wstrb;
  assign m_axil_araddr = sel1 ? s1_axil_araddr : s0_axil_araddr;
  assign m_axil_arprot = sel1 ? s1_axil_arprot : s0_axil_arprot;

  // AW and W complete independently; a channel already accepted is masked off.
  assign m_axil_awvalid = in_wr & sel_awvalid & ~aw_done;
  assign m_axil_wvalid  = in_wr & sel_wvalid & ~w_done;
  assign m_axil_bready  = in_wresp & sel_bready;
  assign m_axil_arvalid = in_rd & sel_arvalid;
  assign m_axil_rready  = in_rdata & sel_rready;

  assign aw_rdy = in_wr & m_axil_awready & ~aw_done;
  assign w_rdy  = in_wr & m_axil_wready & ~w_done;
  assign b_vld  = in_wresp & m_axil_bvalid;
  assign ar_rdy = in_rd & m_axil_arready;
  assign r_vld  = in_rdata & m_axil_rvalid;

  assign s0_axil_awready = aw_rdy & ~sel1;
  assign s1_axil_awready = aw_rdy & sel1;
  assign s0_axil_wready  = w_rdy & ~sel1;
  assign s1_axil_wready  = w_rdy & sel1;
  assign s0_axil_bvalid  = b_vld & ~sel1;
  assign s1_axil_bvalid  = b_vld & sel1;
  assign s0_axil_arready = ar_rdy & ~sel1;
  assign s1_axil_arready = ar_rdy & sel1;
  assign s0_axil_rvalid  = r_vld & ~sel1;
  assign s1_axil_rvalid  = r_vld & sel1;

  // Response payloads are qualified by the per-master valids above.
  assign s0_axil_bresp = m_axil_bresp;
  assign s1_axil_bresp = m_axil_bresp;
  assign s0_axil_rdata = m_axil_rdata;
  assign s1_axil_rdata = m_axil_rdata;
  assign s0_axil_rresp = m_axil_rresp;
  assign s1_axil_rresp = m_axil_rresp;

  assign aw_hs = m_axil_awvalid & m_axil_awready;
  assign w_hs  = m_axil_wvalid & m_axil_wready;
  assign b_hs  = m_axil_bvalid & m_axil_bready;
  assign ar_hs = m_axil_arvalid & m_axil_arready;
  assign r_hs  = m_axil_rvalid & m_axil_rready;

  always_ff @(posedge clka) begin
    if (rstb) begin
      state   <= IDLE;
      grant   <= 2'd0;
      ptr     <= 2'd0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant <= pick;
            ptr   <= pick + 2'd1;
            state <= pick[0] ? RD : WR;
          end
        end
        WR: begin
          // Handshakes of this cycle count toward completion immediately.
          aw_done <= aw_done | aw_hs;
          w_done  <= w_done | w_hs;
          if ((aw_done | aw_hs) && (w_done | w_hs)) state <= WRESP;
        end
        WRESP: begin
          if (b_hs) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            state   <= IDLE;
          end
        end
        RD: begin
          if (ar_hs) state <= RDATA;
        end
        RDATA: begin
          if (r_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_bram_port_arbiter.sv
// tb/tb_axil_bram_port_arbiter.sv - directed self-checking bench for axil_bram_port_arbiter

module tb_axil_bram_port_arbiter;

  logic        clka = 1'b0;
  logic        rstb = 1'b1;

  logic [8:0]  s0_axil_awaddr = '0, s1_axil_awaddr = '0, s0_axil_araddr = '0, s1_axil_araddr = '0;
  logic [2:0]  s0_axil_awprot = '0, s1_axil_awprot = '0, s0_axil_arprot = '0, s1_axil_arprot = '0;
  logic        s0_axil_awvalid = 0, s1_axil_awvalid = 0, s0_axil_wvalid = 0, s1_axil_wvalid = 0;
  logic        s0_axil_arvalid = 0, s1_axil_arvalid = 0;
  logic        s0_axil_bready = 0, s1_axil_bready = 0, s0_axil_rready = 0, s1_axil_rready = 0;
  logic [31:0] s0_axil_wdata = '0, s1_axil_wdata = '0;
  logic [3:0]  s0_axil_wstrb = '0, s1_axil_wstrb = '0;
  logic        s0_axil_awready, s1_axil_awready, s0_axil_wready, s1_axil_wready;
  logic        s0_axil_arready, s1_axil_arready, s0_axil_bvalid, s1_axil_bvalid;
  logic        s0_axil_rvalid, s1_axil_rvalid;
  logic [1:0]  s0_axil_bresp, s1_axil_bresp, s0_axil_rresp, s1_axil_rresp;
  logic [31:0] s0_axil_rdata, s1_axil_rdata;

  logic [8:0]  m_axil_awaddr, m_axil_araddr;
  logic [2:0]  m_axil_awprot, m_axil_arprot;
  logic        m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready;
  logic [31:0] m_axil_wdata;
  logic [3:0]  m_axil_wstrb;
  logic        m_axil_awready = 1, m_axil_wready = 1, m_axil_arready = 1;
  logic        m_axil_bvalid = 0, m_axil_rvalid = 0;
  logic [1:0]  m_axil_bresp = '0, m_axil_rresp = '0;
  logic [31:0] m_axil_rdata = '0;
  logic [1:0]  grant;
  logic        busy;

  int pass_cnt = 0;
  int total_cnt = 0;
  int viol = 0;
  int n_aw = 0, n_w = 0;

  axil_bram_port_arbiter dut (
    .clka(clka), .rstb(rstb),
    .s0_axil_awaddr(s0_axil_awaddr), .s0_axil_awprot(s0_axil_awprot),
    .s0_axil_awvalid(s0_axil_awvalid), .s0_axil_awready(s0_axil_awready),
    .s0_axil_wdata(s0_axil_wdata), .s0_axil_wstrb(s0_axil_wstrb),
    .s0_axil_wvalid(s0_axil_wvalid), .s0_axil_wready(s0_axil_wready),
    .s0_axil_bresp(s0_axil_bresp), .s0_axil_bvalid(s0_axil_bvalid), .s0_axil_bready(s0_axil_bready),
    .s0_axil_araddr(s0_axil_araddr), .s0_axil_arprot(s0_axil_arprot),
    .s0_axil_arvalid(s0_axil_arvalid), .s0_axil_arready(s0_axil_arready),
    .s0_axil_rdata(s0_axil_rdata), .s0_axil_rresp(s0_axil_rresp),
    .s0_axil_rvalid(s0_axil_rvalid), .s0_axil_rready(s0_axil_rready),
    .s1_axil_awaddr(s1_axil_awaddr), .s1_axil_awprot(s1_axil_awprot),
    .s1_axil_awvalid(s1_axil_awvalid), .s1_axil_awready(s1_axil_awready),
    .s1_axil_wdata(s1_axil_wdata), .s1_axil_wstrb(s1_axil_wstrb),
    .s1_axil_wvalid(s1_axil_wvalid), .s1_axil_wready(s1_axil_wready),
    .s1_axil_bresp(s1_axil_bresp), .s1_axil_bvalid(s1_axil_bvalid), .s1_axil_bready(s1_axil_bready),
    .s1_axil_araddr(s1_axil_araddr), .s1_axil_arprot(s1_axil_arprot),
    .s1_axil_arvalid(s1_axil_arvalid), .s1_axil_arready(s1_axil_arready),
    .s1_axil_rdata(s1_axil_rdata), .s1_axil_rresp(s1_axil_rresp),
    .s1_axil_rvalid(s1_axil_rvalid), .s1_axil_rready(s1_axil_rready),
    .m_axil_awaddr(m_axil_awaddr), .m_axil_awprot(m_axil_awprot),
    .m_axil_awvalid(m_axil_awvalid), .m_axil_awready(m_axil_awready),
    .m_axil_wdata(m_axil_wdata), .m_axil_wstrb(m_axil_wstrb),
    .m_axil_wvalid(m_axil_wvalid), .m_axil_wready(m_axil_wready),
    .m_axil_bresp(m_axil_bresp), .m_axil_bvalid(m_axil_bvalid), .m_axil_bready(m_axil_bready),
    .m_axil_araddr(m_axil_araddr), .m_axil_arprot(m_axil_arprot),
    .m_axil_arvalid(m_axil_arvalid), .m_axil_arready(m_axil_arready),
    .m_axil_rdata(m_axil_rdata), .m_axil_rresp(m_axil_rresp),
    .m_axil_rvalid(m_axil_rvalid), .m_axil_rready(m_axil_rready),
    .grant(grant), .busy(busy)
  );

  always #5 clka = ~clka;

  // Zero-wait BRAM slave: handshakes sampled mid-cycle, responses driven just after the edge.
  // Addresses with bit 8 set answer SLVERR so the response code path is visible.
  logic [31:0] mem [0:127];
  logic        got_aw = 0, got_w = 0;
  logic [8:0]  aw_q = '0;
  logic [31:0] wd_q = '0;
  logic [3:0]  ws_q = '0;

  always begin
    logic s_rst, s_aw, s_w, s_b, s_ar, s_r;
    logic [8:0]  c_awaddr, c_araddr;
    logic [31:0] c_wdata;
    logic [3:0]  c_wstrb;
    @(negedge clka);
    s_rst = rstb;
    s_aw = m_axil_awvalid & m_axil_awready;
    s_w  = m_axil_wvalid & m_axil_wready;
    s_b  = m_axil_bvalid & m_axil_bready;
    s_ar = m_axil_arvalid & m_axil_arready;
    s_r  = m_axil_rvalid & m_axil_rready;
    c_awaddr = m_axil_awaddr;
    c_araddr = m_axil_araddr;
    c_wdata  = m_axil_wdata;
    c_wstrb  = m_axil_wstrb;
    if (s_aw) n_aw++;
    if (s_w) n_w++;
    @(posedge clka);
    #1;
    if (s_rst) begin
      got_aw = 0; got_w = 0; m_axil_bvalid = 0; m_axil_rvalid = 0;
    end else begin
      if (s_aw) begin got_aw = 1; aw_q = c_awaddr; end
      if (s_w) begin got_w = 1; wd_q = c_wdata; ws_q = c_wstrb; end
      if (s_b) m_axil_bvalid = 0;
      if (s_r) m_axil_rvalid = 0;
      if (got_aw && got_w && !m_axil_bvalid) begin
        for (int k = 0; k < 4; k++)
          if (ws_q[k]) mem[aw_q[8:2]][8*k +: 8] = wd_q[8*k +: 8];
        m_axil_bresp = aw_q[8] ? 2'b10 : 2'b00;
        m_axil_bvalid = 1;
        got_aw = 0; got_w = 0;
      end
      if (s_ar) begin
        m_axil_rdata = mem[c_araddr[8:2]];
        m_axil_rresp = c_araddr[8] ? 2'b10 : 2'b00;
        m_axil_rvalid = 1;
      end
    end
  end

  // Isolation monitor: non-granted master fully quiet, nothing forwarded while idle.
  always @(negedge clka) begin
    if ((!busy || grant[1]) &&
        |{s0_axil_awready, s0_axil_wready, s0_axil_bvalid, s0_axil_arready, s0_axil_rvalid}) viol++;
    if ((!busy || !grant[1]) &&
        |{s1_axil_awready, s1_axil_wready, s1_axil_bvalid, s1_axil_arready, s1_axil_rvalid}) viol++;
    if (!busy && |{m_axil_awvalid, m_axil_wvalid, m_axil_arvalid, m_axil_bready, m_axil_rready}) viol++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic do_reset();
    s0_axil_awvalid = 0; s0_axil_wvalid = 0; s0_axil_arvalid = 0;
    s1_axil_awvalid = 0; s1_axil_wvalid = 0; s1_axil_arvalid = 0;
    s0_axil_bready = 0; s1_axil_bready = 0; s0_axil_rready = 0; s1_axil_rready = 0;
    m_axil_awready = 1; m_axil_wready = 1; m_axil_arready = 1;
    rstb = 1;
    tick();
    rstb = 0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clka);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++;
    if (grant !== 2'd0) $display("FAIL reset_grant: got %0d expected 0", grant); else pass_cnt++;
    total_cnt++;
    if ({s0_axil_awready, s0_axil_wready, s0_axil_bvalid, s0_axil_arready, s0_axil_rvalid,
         s1_axil_awready, s1_axil_wready, s1_axil_bvalid, s1_axil_arready, s1_axil_rvalid,
         m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready} !== 15'd0)
      $display("FAIL reset_handshake_signals: some ready/valid high, expected all 0");
    else pass_cnt++;
  endtask

  task automatic test_single_write();
    int a0, w0;
    do_reset();
    a0 = n_aw; w0 = n_w;
    s0_axil_awaddr = 9'h010; s0_axil_wdata = 32'hDEADBEEF; s0_axil_wstrb = 4'hF;
    s0_axil_awvalid = 1; s0_axil_wvalid = 1; s0_axil_bready = 1;
    @(negedge clka);
    total_cnt++;
    if (m_axil_awvalid !== 1'b0) $display("FAIL wr1_idle_no_forward: got %b expected 0", m_axil_awvalid);
    else pass_cnt++;
    tick();
    @(negedge clka);
    total_cnt++;
    if ({m_axil_awvalid, m_axil_wvalid, s0_axil_awready, s0_axil_wready} !== 4'b1111)
      $display("FAIL wr1_cycle2_valids: got %b expected 1111",
               {m_axil_awvalid, m_axil_wvalid, s0_axil_awready, s0_axil_wready});
    else pass_cnt++;
    total_cnt++;
    if (m_axil_awaddr !== 9'h010 || m_axil_wdata !== 32'hDEADBEEF || m_axil_wstrb !== 4'hF)
      $display("FAIL wr1_payload: got %h/%h/%h expected 010/deadbeef/f",
               m_axil_awaddr, m_axil_wdata, m_axil_wstrb);
    else pass_cnt++;
    total_cnt++;
    if (grant !== 2'd0 || busy !== 1'b1) $display("FAIL wr1_grant: got %0d busy %b expected 0 busy 1", grant, busy);
    else pass_cnt++;
    tick();
    s0_axil_awvalid = 0; s0_axil_wvalid = 0;
    @(negedge clka);
    total_cnt++;
    if (s0_axil_bvalid !== 1'b1 || s0_axil_bresp !== 2'b00)
      $display("FAIL wr1_cycle3_bresp: got valid %b resp %b expected 1 00", s0_axil_bvalid, s0_axil_bresp);
    else pass_cnt++;
    tick();
    @(negedge clka);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL wr1_done_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++;
    if (n_aw - a0 != 1 || n_w - w0 != 1)
      $display("FAIL wr1_handshake_count: got aw %0d w %0d expected 1 1", n_aw - a0, n_w - w0);
    else pass_cnt++;
  endtask

  task automatic test_two_masters();
    int ng;
    logic pb;
    logic [1:0] g [0:2];
    do_reset();
    ng = 0; pb = 0;
    s0_axil_awaddr = 9'h020; s0_axil_wdata = 32'h11112222; s0_axil_wstrb = 4'hF;
    s0_axil_awvalid = 1; s0_axil_wvalid = 1; s0_axil_bready = 1;
    s1_axil_araddr = 9'h010; s1_axil_arvalid = 1; s1_axil_rready = 1;
    for (int c = 0; c < 40 && ng < 3; c++) begin
      @(negedge clka);
      if (busy && !pb) begin g[ng] = grant; ng++; end
      pb = busy;
    end
    total_cnt++;
    if (ng != 3) $display("FAIL rr2_timeout: got %0d grants expected 3", ng);
    else pass_cnt++;
    total_cnt++;
    if (ng == 3 && {g[0], g[1], g[2]} !== {2'd0, 2'd3, 2'd0})
      $display("FAIL rr2_order: got %0d,%0d,%0d expected 0,3,0", g[0], g[1], g[2]);
    else if (ng == 3) pass_cnt++;
  endtask

  task automatic test_all_slots();
    int ng, gaps_bad, idle_run;
    logic pb;
    logic [1:0] g [0:4];
    do_reset();
    ng = 0; gaps_bad = 0; idle_run = 0; pb = 0;
    s0_axil_awaddr = 9'h020; s1_axil_awaddr = 9'h030; s0_axil_araddr = 9'h020; s1_axil_araddr = 9'h030;
    s0_axil_wstrb = 4'hF; s1_axil_wstrb = 4'hF;
    s0_axil_awvalid = 1; s0_axil_wvalid = 1; s0_axil_arvalid = 1; s0_axil_bready = 1; s0_axil_rready = 1;
    s1_axil_awvalid = 1; s1_axil_wvalid = 1; s1_axil_arvalid = 1; s1_axil_bready = 1; s1_axil_rready = 1;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      @(negedge clka);
      if (busy && !pb) begin
        g[ng] = grant; ng++;
        if (idle_run != 1) gaps_bad++;
      end
      idle_run = busy ? 0 : idle_run + 1;
      pb = busy;
    end
    total_cnt++;
    if (ng != 5 || {g[0], g[1], g[2], g[3], g[4]} !== {2'd0, 2'd1, 2'd2, 2'd3, 2'd0})
      $display("FAIL rr4_order: got %0d grants %0d,%0d,%0d,%0d,%0d expected 0,1,2,3,0",
               ng, g[0], g[1], g[2], g[3], g[4]);
    else pass_cnt++;
    total_cnt++;
    if (gaps_bad != 0) $display("FAIL rr4_idle_gap: got %0d gaps not 1 cycle expected 0", gaps_bad);
    else pass_cnt++;
  endtask

  task automatic test_aw_after_w();
    int a0, w0;
    do_reset();
    a0 = n_aw; w0 = n_w;
    s0_axil_awaddr = 9'h140; s0_axil_wdata = 32'h12345678; s0_axil_wstrb = 4'h3;
    s0_axil_awvalid = 1; s0_axil_wvalid = 1; s0_axil_bready = 1;
    m_axil_awready = 0;
    @(negedge clka);
    tick();
    @(negedge clka);
    total_cnt++;
    if ({m_axil_wvalid, s0_axil_wready, m_axil_awvalid, s0_axil_awready} !== 4'b1110)
      $display("FAIL aww_first_cycle: got %b expected 1110",
               {m_axil_wvalid, s0_axil_wready, m_axil_awvalid, s0_axil_awready});
    else pass_cnt++;
    tick();
    s0_axil_wvalid = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clka);
      total_cnt++;
      if ({busy, m_axil_wvalid, m_axil_awvalid, s0_axil_bvalid} !== 4'b1010)
        $display("FAIL aww_stall: got busy/wv/awv/bv %b expected 1010",
                 {busy, m_axil_wvalid, m_axil_awvalid, s0_axil_bvalid});
      else pass_cnt++;
      tick();
    end
    m_axil_awready = 1;
    @(negedge clka);
    total_cnt++;
    if (s0_axil_awready !== 1'b1 || m_axil_awaddr !== 9'h140)
      $display("FAIL aww_aw_accept: got ready %b addr %h expected 1 140", s0_axil_awready, m_axil_awaddr);
    else pass_cnt++;
    tick();
    s0_axil_awvalid = 0;
    @(negedge clka);
    total_cnt++;
    if (s0_axil_bvalid !== 1'b1 || s0_axil_bresp !== 2'b10)
      $display("FAIL aww_bresp: got valid %b resp %b expected 1 10", s0_axil_bvalid, s0_axil_bresp);
    else pass_cnt++;
    tick();
    @(negedge clka);
    total_cnt++;
    if (n_aw - a0 != 1 || n_w - w0 != 1 || busy !== 1'b0)
      $display("FAIL aww_counts: got aw %0d w %0d busy %b expected 1 1 0", n_aw - a0, n_w - w0, busy);
    else pass_cnt++;
  endtask

  task automatic test_read_stall();
    do_reset();
    s1_axil_araddr = 9'h010; s1_axil_arvalid = 1; s1_axil_rready = 0;
    @(negedge clka);
    tick();
    @(negedge clka);
    total_cnt++;
    if (grant !== 2'd3 || m_axil_arvalid !== 1'b1 || s1_axil_arready !== 1'b1)
      $display("FAIL rst_ar_phase: got grant %0d arv %b arr %b expected 3 1 1",
               grant, m_axil_arvalid, s1_axil_arready);
    else pass_cnt++;
    tick();
    s1_axil_arvalid = 0;
    s0_axil_awaddr = 9'h060; s0_axil_wdata = 32'hCAFEF00D; s0_axil_wstrb = 4'hF;
    s0_axil_awvalid = 1; s0_axil_wvalid = 1; s0_axil_bready = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clka);
      total_cnt++;
      if (s1_axil_rvalid !== 1'b1 || s1_axil_rdata !== 32'hDEADBEEF || grant !== 2'd3 ||
          s0_axil_awready !== 1'b0 || s1_axil_rresp !== 2'b00)
        $display("FAIL rst_stall_cycle%0d: got rv %b rdata %h grant %0d s0awr %b expected 1 deadbeef 3 0",
                 c, s1_axil_rvalid, s1_axil_rdata, grant, s0_axil_awready);
      else pass_cnt++;
      tick();
    end
    s1_axil_rready = 1;
    @(negedge clka);
    tick();
    @(negedge clka);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL rst_idle_after_r: got %b expected 0", busy); else pass_cnt++;
    tick();
    @(negedge clka);
    total_cnt++;
    if (grant !== 2'd0 || busy !== 1'b1) $display("FAIL rst_s0_grant: got %0d busy %b expected 0 1", grant, busy);
    else pass_cnt++;
    tick();
    s0_axil_awvalid = 0; s0_axil_wvalid = 0;
    tick();
  endtask

  task automatic test_reset_in_wresp();
    logic seen3;
    do_reset();
    s0_axil_awaddr = 9'h050; s0_axil_wdata = 32'h55AA55AA; s0_axil_wstrb = 4'hF;
    s0_axil_awvalid = 1; s0_axil_wvalid = 1; s0_axil_bready = 0;
    tick();
    tick();
    s0_axil_awvalid = 0; s0_axil_wvalid = 0;
    @(negedge clka);
    total_cnt++;
    if (s0_axil_bvalid !== 1'b1) $display("FAIL rwr_in_wresp: got %b expected 1", s0_axil_bvalid);
    else pass_cnt++;
    tick();
    rstb = 1;
    tick();
    rstb = 0;
    s0_axil_awvalid = 1; s0_axil_wvalid = 1; s0_axil_bready = 1;
    s1_axil_araddr = 9'h050; s1_axil_arvalid = 1; s1_axil_rready = 1;
    @(negedge clka);
    total_cnt++;
    if ({busy, s0_axil_awready, s0_axil_wready, s0_axil_bvalid, s1_axil_arready, s1_axil_rvalid,
         m_axil_awvalid, m_axil_wvalid, m_axil_bready, m_axil_arvalid, m_axil_rready} !== 11'd0)
      $display("FAIL rwr_after_reset: some busy/ready/valid high, expected all 0");
    else pass_cnt++;
    tick();
    @(negedge clka);
    total_cnt++;
    if (grant !== 2'd0 || busy !== 1'b1) $display("FAIL rwr_s0_wins: got %0d busy %b expected 0 1", grant, busy);
    else pass_cnt++;
    tick();
    s0_axil_awvalid = 0; s0_axil_wvalid = 0;
    seen3 = 0;
    for (int c = 0; c < 10 && !seen3; c++) begin
      @(negedge clka);
      if (busy && grant == 2'd3) seen3 = 1;
    end
    total_cnt++;
    if (seen3 !== 1'b1) $display("FAIL rwr_s1_next: got %b expected grant 3 seen", seen3); else pass_cnt++;
    do_reset();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    test_reset();
    test_single_write();
    test_two_masters();
    test_all_slots();
    test_aw_after_w();
    test_read_stall();
    test_reset_in_wresp();
    total_cnt++;
    if (viol != 0) $display("FAIL isolation: got %0d violations expected 0", viol); else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
